// File: rtl/spart_pkg.sv
// Shared types and sizing for the SPART baud-rate generator.
package spart_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DB_WIDTH       = 16;
  localparam int OVERSAMPLE_DEF = 16;
endpackage

// File: rtl/spart_baud_gen_if.sv
// Divisor-buffer to baud-generator connection, plus debug visibility of the FSM and counters.
interface spart_baud_gen_if;
  import spart_pkg::*;

  // No valid/ready pair here: {dbHigh, dbLow} is qualified by the isReady level alone,
  // and the enables are single-cycle strobes with no backpressure.
  logic [7:0]          dbLow;
  logic [7:0]          dbHigh;
  logic                isReady;
  logic                rxEnable;
  logic                txEnable;
  logic                running;
  state_t              stateDbg;
  logic [DB_WIDTH-1:0] cntDbg;
  logic [7:0]          osCntDbg;

  modport master (
    output dbLow, dbHigh, isReady,
    input  rxEnable, txEnable, running, stateDbg, cntDbg, osCntDbg
  );

  modport slave (
    input  dbLow, dbHigh, isReady,
    output rxEnable, txEnable, running, stateDbg, cntDbg, osCntDbg
  );
endinterface

// File: rtl/spart_reload_counter.sv
// Down-counter with clear, load and automatic reload when it steps past zero.
module spart_reload_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] loadVal,
  input  logic [WIDTH-1:0] reloadVal,
  output logic [WIDTH-1:0] count,
  output logic             isZero
);
  assign isZero = (count == '0);

  // clear beats load beats count, so an abort always wins over a reload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en) begin
      count <= isZero ? reloadVal : count - WIDTH'(1);
    end
  end
endmodule

// File: rtl/spart_baud_gen.sv
// SPART baud-rate generator: rxEnable every D clocks, txEnable every OVERSAMPLE-th rxEnable.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic             clk,
  input logic             rst,
  spart_baud_gen_if.slave bus
);
  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_TOP = OS_W'(OVERSAMPLE - 1);

  state_t              state, stateNext;
  logic [DB_WIDTH-1:0] divQ, divNext, dNew, cnt;
  logic [OS_W-1:0]     osCnt;
  logic                pend, pendNext, dChange;
  logic                cntZero, osZero, rxEn;
  logic                cntLoad, cntClear, cntEn;
  logic                osLoad, osClear, osEn;

  assign dNew    = {bus.dbHigh, bus.dbLow};
  assign dChange = (dNew != divQ);
  assign rxEn    = (state == RUN) && cntZero;

  assign bus.rxEnable = rxEn;
  assign bus.txEnable = rxEn && osZero;
  assign bus.running  = (state == RUN);
  assign bus.stateDbg = state;
  assign bus.cntDbg   = cnt;
  assign bus.osCntDbg = 8'(osCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      divQ  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= stateNext;
      divQ  <= divNext;
      pend  <= pendNext;
    end
  end

  always_comb begin
    stateNext = state;
    divNext   = divQ;
    pendNext  = pend;
    cntLoad   = 1'b0;
    cntClear  = 1'b0;
    cntEn     = 1'b0;
    osLoad    = 1'b0;
    osClear   = 1'b0;
    osEn      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.isReady && dNew != '0) begin
          stateNext = RUN;
          divNext   = dNew;
          pendNext  = 1'b0;
          cntLoad   = 1'b1;
          osLoad    = 1'b1;
        end
      end
      RUN: begin
        if (!bus.isReady) begin
          stateNext = IDLE;
          pendNext  = 1'b0;
          cntClear  = 1'b1;
          osClear   = 1'b1;
        end else if (cntZero) begin
          // period boundary: a pending divisor takes effect here, os_cnt keeps its phase
          osEn = 1'b1;
          if (pend || dChange) begin
            pendNext = 1'b0;
            if (dNew == '0) begin
              stateNext = IDLE;
              cntClear  = 1'b1;
              osClear   = 1'b1;
              osEn      = 1'b0;
            end else begin
              divNext = dNew;
              cntLoad = 1'b1;
            end
          end else begin
            cntEn = 1'b1;
          end
        end else begin
          cntEn    = 1'b1;
          pendNext = dChange;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  spart_reload_counter #(.WIDTH(DB_WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cntClear),
    .load     (cntLoad),
    .en       (cntEn),
    .loadVal  (dNew - DB_WIDTH'(1)),
    .reloadVal(divQ - DB_WIDTH'(1)),
    .count    (cnt),
    .isZero   (cntZero)
  );

  spart_reload_counter #(.WIDTH(OS_W)) u_os_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (osClear),
    .load     (osLoad),
    .en       (osEn),
    .loadVal  (OS_TOP),
    .reloadVal(OS_TOP),
    .count    (osCnt),
    .isZero   (osZero)
  );
endmodule

// File: tb/tb_spart_baud_gen.sv
// Directed bench for spart_baud_gen: vector table of pulse intervals plus multi-cycle sequences.
module tb_spart_baud_gen;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  spart_baud_gen_if bus();

  spart_baud_gen #(.OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          rxFirst;
    int          rxPeriod;
    int          txFirst;
    int          txPeriod;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] expQ[$];
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      0:       return bus.rxEnable;
      1:       return bus.txEnable;
      default: return !bus.running;
    endcase
  endfunction

  // ticks until the selected signal is seen, counting the first edge; limit+1 on timeout
  task automatic waitFor(input int sel, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sigVal(sel) && n <= limit);
  endtask

  task automatic setD(input logic [15:0] d);
    bus.dbHigh = d[15:8];
    bus.dbLow  = d[7:0];
  endtask

  // leave RUN, then present d with isReady high so the next edge is the capture edge
  task automatic restart(input logic [15:0] d);
    bus.isReady = 1'b0;
    tick();
    tick();
    setD(d);
    bus.isReady = 1'b1;
  endtask

  initial begin
    int n;
    int rxCount;

    vecs[0] = '{16'h0001,   1,   1,   16,   16};
    vecs[1] = '{16'h0002,   2,   2,   32,   32};
    vecs[2] = '{16'h0003,   3,   3,   48,   48};
    vecs[3] = '{16'h0004,   4,   4,   64,   64};
    vecs[4] = '{16'h00AB, 171, 171, 2736, 2736};

    // reset held with a valid divisor present: nothing may start
    setD(16'h0004);
    bus.isReady = 1'b1;
    repeat (3) tick();
    check("reset_rx", int'(bus.rxEnable), 0);
    check("reset_tx", int'(bus.txEnable), 0);
    check("reset_running", int'(bus.running), 0);
    check("reset_state", int'(bus.stateDbg), int'(IDLE));
    check("reset_cnt", int'(bus.cntDbg), 0);
    rst = 1'b1;
    waitFor(0, 20, n);
    check("post_reset_first_rx", n, 4);

    foreach (vecs[i]) begin
      restart(vecs[i].d);
      waitFor(0, 4 * vecs[i].rxPeriod + 10, n);
      check($sformatf("vec%0d_rx_first", i), n, vecs[i].rxFirst);
      waitFor(0, 4 * vecs[i].rxPeriod + 10, n);
      check($sformatf("vec%0d_rx_period", i), n, vecs[i].rxPeriod);
      restart(vecs[i].d);
      waitFor(1, 2 * vecs[i].txPeriod + 10, n);
      check($sformatf("vec%0d_tx_first", i), n, vecs[i].txFirst);
      waitFor(1, 2 * vecs[i].txPeriod + 10, n);
      check($sformatf("vec%0d_tx_period", i), n, vecs[i].txPeriod);
    end

    // D=1: rxEnable every cycle, three consecutive tx intervals of 16
    restart(16'h0001);
    waitFor(1, 40, n);
    for (int k = 0; k < 3; k++) begin
      waitFor(1, 40, n);
      check($sformatf("d1_tx_interval%0d", k), n, 16);
    end
    rxCount = 0;
    repeat (16) begin
      tick();
      rxCount += int'(bus.rxEnable);
    end
    check("d1_rx_every_cycle", rxCount, 16);

    // 0xAB -> 0x2F mid-period: old period completes, tx phase carries over
    restart(16'h00AB);
    waitFor(0, 400, n);
    check("chg_first_rx", n, 171);
    repeat (50) tick();
    setD(16'h002F);
    expQ.push_back(16'd121);
    expQ.push_back(16'd47);
    expQ.push_back(16'd47);
    while (expQ.size() > 0) begin
      logic [15:0] e;
      e = expQ.pop_front();
      waitFor(0, 400, n);
      check("chg_rx_interval", n, int'(e));
    end
    waitFor(1, 1500, n);
    check("chg_tx_phase", n, 12 * 47);
    waitFor(1, 1500, n);
    check("chg_tx_period", n, 16 * 47);

    // D=0 with isReady: stays idle
    restart(16'h0000);
    rxCount = 0;
    repeat (8) begin
      tick();
      rxCount += int'(bus.rxEnable) + int'(bus.running);
    end
    check("d0_idle_activity", rxCount, 0);
    check("d0_idle_state", int'(bus.stateDbg), int'(IDLE));

    // running at 3, then D=0 stops at the next boundary
    setD(16'h0003);
    waitFor(0, 20, n);
    check("d3_first_rx", n, 3);
    tick();
    tick();
    setD(16'h0000);
    waitFor(2, 20, n);
    check("d0_stop_at_boundary", n, 2);

    // isReady falls mid-period
    restart(16'h0005);
    waitFor(0, 30, n);
    check("d5_first_rx", n, 5);
    tick();
    tick();
    bus.isReady = 1'b0;
    tick();
    check("ready_fall_running", int'(bus.running), 0);
    check("ready_fall_rx", int'(bus.rxEnable), 0);
    check("ready_fall_os_cnt", int'(bus.osCntDbg), 0);
    tick();
    setD(16'h0002);
    bus.isReady = 1'b1;
    waitFor(1, 100, n);
    check("restart_d2_first_tx", n, 32);

    // isReady falls in a boundary cycle: that pulse stands, then idle
    waitFor(0, 10, n);
    check("d2_rx_interval", n, 2);
    bus.isReady = 1'b0;
    #1;
    check("boundary_fall_rx_kept", int'(bus.rxEnable), 1);
    tick();
    check("boundary_fall_running", int'(bus.running), 0);

    // asynchronous reset between edges while rx and tx are high
    restart(16'h0001);
    waitFor(1, 40, n);
    check("pre_async_tx", n, 16);
    #2;
    rst = 1'b0;
    #1;
    check("async_rx", int'(bus.rxEnable), 0);
    check("async_tx", int'(bus.txEnable), 0);
    check("async_running", int'(bus.running), 0);
    tick();
    rst = 1'b1;
    waitFor(0, 10, n);
    check("post_async_capture_rx", n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
